pc_fetch_unit: RTL and testbench

Program-counter and fetch-control stage sitting directly upstream of the 4 KB instruction memory in the MIPS single-cycle datapath.
- Holds the architectural PC and drives it as the instruction-memory word address.
- Selects the next PC from sequential, branch, jump and jump-register sources.
- Gates the returned instruction to decode, counts issued instructions, and traps on illegal fetch targets with a sticky fault state.

---
 rtl/pc_fetch_unit.sv | 104 ++++++++++
 tb/tb_pc_fetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - MIPS program counter, next-PC select and fetch gating with sticky fetch fault
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic [31:0] issue_count,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [31:0] LAST_PC      = 32'(IMEM_BYTES - 4);
    localparam logic [1:0]  CAUSE_ALIGN  = 2'b01;
    localparam logic [1:0]  CAUSE_RANGE  = 2'b10;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] issue_q;
    logic        fault_q;
    logic [1:0]  cause_q;
    logic [31:0] fault_pc_q;

    logic [31:0] seq_pc;
    logic [31:0] branch_disp;
    logic [31:0] target_d;
    logic        misaligned;
    logic        out_of_range;

    always_comb begin
        seq_pc      = pc_q + 32'd4;
        branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};
        target_d    = seq_pc;
        if (jump_reg) begin
            target_d = jr_target;
        end else if (jump) begin
            target_d = {seq_pc[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            target_d = seq_pc + branch_disp;
        end
        misaligned   = (target_d[1:0] != 2'b00);
        out_of_range = (target_d > LAST_PC);
    end

    // A faulting fetch still counts: the instruction at pc_q was issued this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            issue_q    <= 32'd0;
            fault_q    <= 1'b0;
            cause_q    <= 2'b00;
            fault_pc_q <= 32'd0;
        end else begin
            case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (!stall) begin
                        issue_q <= issue_q + 32'd1;
                        if (misaligned || out_of_range) begin
                            state_q    <= FAULT;
                            fault_q    <= 1'b1;
                            cause_q    <= misaligned ? CAUSE_ALIGN : CAUSE_RANGE;
                            fault_pc_q <= target_d;
                        end else begin
                            pc_q <= target_d;
                        end
                    end
                end
                FAULT:   state_q <= FAULT;
                default: state_q <= BOOT;
            endcase
        end
    end

    assign pc_out      = pc_q;
    assign pc_plus4    = seq_pc;
    assign instr_valid = (state_q == RUN) && !stall;
    assign instr_out   = instr_valid ? instr_in : 32'h0000_0000;
    assign issue_count = issue_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed and randomized checks of pc_fetch_unit against a behavioural model
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jr_target;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] issue_count;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index),
        .jump_reg(jump_reg), .jr_target(jr_target),
        .instr_in(instr_in), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .instr_out(instr_out), .instr_valid(instr_valid),
        .issue_count(issue_count), .fault(fault),
        .fault_cause(fault_cause), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;

    localparam int M_BOOT = 0, M_RUN = 1, M_FAULT = 2;

    int          total = 0;
    int          bad   = 0;
    int          m_state;
    logic [31:0] m_pc, m_cnt, m_fpc;
    logic        m_fault;
    logic [1:0]  m_cause;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_BOOT; m_pc = 32'h0; m_cnt = 32'h0;
        m_fault = 1'b0; m_cause = 2'b00; m_fpc = 32'h0;
    endtask

    // One cycle: apply inputs, compare the pre-edge view, clock, advance the model.
    task automatic step(input logic r, input logic s, input logic br, input logic [15:0] off,
                        input logic j, input logic [25:0] idx, input logic jr, input logic [31:0] jrt);
        logic        exp_valid;
        logic [31:0] t, ins;
        int          so;
        ins = $urandom;
        rst = r; stall = s; branch_taken = br; branch_offset = off;
        jump = j; jump_index = idx; jump_reg = jr; jr_target = jrt; instr_in = ins;
        #1;
        exp_valid = (m_state == M_RUN) && !s;
        chk("pc_out", pc_out, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
        chk("instr_out", instr_out, exp_valid ? ins : 32'h0);
        chk("issue_count", issue_count, m_cnt);
        chk("fault", {31'd0, fault}, {31'd0, m_fault});
        chk("fault_cause", {30'd0, fault_cause}, {30'd0, m_cause});
        chk("fault_pc", fault_pc, m_fpc);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (m_state == M_BOOT) begin
            m_state = M_RUN;
        end else if (m_state == M_RUN && !s) begin
            so = $signed(off);
            if (jr)      t = jrt;
            else if (j)  t = ((m_pc + 32'd4) & 32'hF000_0000) + 32'(idx) * 32'd4;
            else if (br) t = m_pc + 32'd4 + 32'(so * 4);
            else         t = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
            if (t % 4 != 0) begin
                m_state = M_FAULT; m_fault = 1'b1; m_cause = 2'b01; m_fpc = t;
            end else if (t > 32'd4092) begin
                m_state = M_FAULT; m_fault = 1'b1; m_cause = 2'b10; m_fpc = t;
            end else begin
                m_pc = t;
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0;
        jump = 1'b0; jump_index = 26'h0; jump_reg = 1'b0; jr_target = 32'h0; instr_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Boot cycle and four sequential fetches
        idle();
        chk("boot_to_run_pc", pc_out, 32'h0);
        repeat (4) idle();
        chk("seq_pc_10", pc_out, 32'h10);
        chk("seq_count_4", issue_count, 32'd4);

        step(1'b0, 1'b0, 1'b1, 16'd4, 1'b0, 26'h0, 1'b0, 32'h0);
        chk("branch_fwd", pc_out, 32'h24);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'd6, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'd8, 1'b0, 32'h0);
        chk("jump_20", pc_out, 32'h20);
        step(1'b0, 1'b0, 1'b1, 16'd3, 1'b1, 26'd9, 1'b1, 32'h40);
        chk("prio_jr", pc_out, 32'h40);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'd8, 1'b0, 32'h0);

        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b0, 16'h0, i[0], 26'd100, 1'b0, 32'h0);
        chk("stall_hold_pc", pc_out, 32'h20);
        idle();
        chk("stall_release", pc_out, 32'h24);

        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 26'd2, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 26'h0, 1'b0, 32'h0);
        chk("branch_self", pc_out, 32'h8);

        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h22);
        chk("jr_misaligned_cause", {30'd0, fault_cause}, 32'd1);
        chk("jr_misaligned_fpc", fault_pc, 32'h22);
        repeat (3) step(1'b0, 1'b0, 1'b1, 16'd1, 1'b1, 26'd1, 1'b1, 32'h4);
        do_reset();
        idle();

        // Randomized redirects; re-reset whenever the model reaches the fault state
        for (int i = 0; i < 400; i++) begin
            logic [31:0] jt;
            logic [25:0] ji;
            if (m_state == M_FAULT && ($urandom % 4 == 0)) begin
                do_reset();
            end else begin
                jt = $urandom_range(0, 1023) * 4;
                if ($urandom % 8 == 0) jt = jt + $urandom_range(1, 3);
                if ($urandom % 16 == 0) jt = jt + 32'h1000;
                ji = 26'($urandom_range(0, 1023));
                if ($urandom % 16 == 0) ji = 26'($urandom);
                step(($urandom % 50) == 0, ($urandom % 4) == 0,
                     ($urandom % 3) == 0, 16'($urandom_range(0, 40) - 20),
                     ($urandom % 5) == 0, ji, ($urandom % 6) == 0, jt);
            end
        end

        // Sequential run off the end of memory
        do_reset();
        idle();
        repeat (1023) idle();
        chk("end_pc_ffc", pc_out, 32'hFFC);
        idle();
        chk("end_fault", {31'd0, fault}, 32'd1);
        chk("end_cause", {30'd0, fault_cause}, 32'd2);
        chk("end_fpc", fault_pc, 32'h1000);
        chk("end_pc_hold", pc_out, 32'hFFC);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
